// File: rtl/pp_pkg.sv
// Shared widths, encodings and FSM state type for the partial-product lane scheduler.
package pp_pkg;

  localparam int unsigned IMG_W = 8;
  localparam int unsigned WGT_W = 4;
  localparam int unsigned EXP_W = 6;
  localparam int unsigned DPP_W = 4;

  localparam logic [2:0] WGT_ZERO_EXP = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT
  } state_e;

endpackage

// File: rtl/pp_lane_compute.sv
// Combinational per-lane partial product: denormalized mantissa and product exponent.
module pp_lane_compute
  import pp_pkg::*;
(
  input  logic [IMG_W-1:0] img,
  input  logic [WGT_W-1:0] wgt,
  output logic [DPP_W-1:0] denorm,
  output logic [EXP_W-1:0] lane_exp
);

  logic is_zero;

  always_comb begin
    // Negative zero images (sign set, rest clear) are zero as well.
    is_zero = (img[6:0] == 7'd0) || (wgt[2:0] == WGT_ZERO_EXP);
    if (is_zero) begin
      denorm   = '0;
      lane_exp = '0;
    end else begin
      denorm   = {img[7] ^ wgt[3], 1'b1, img[1:0]};
      lane_exp = {1'b0, img[6:2]} + {3'b000, wgt[2:0]};
    end
  end

endmodule

// File: rtl/pp_lane_scheduler.sv
// Two-pass lane scheduler: SCAN finds the group max exponent, EMIT streams aligned PPs.
module pp_lane_scheduler
  import pp_pkg::*;
#(
  parameter  int LANES  = 9,
  localparam int LANE_W = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*8-1:0]      in_images,
  input  logic [LANES*4-1:0]      in_weights,
  output logic                    pp_valid,
  input  logic                    pp_ready,
  output logic [3:0]              pp_denorm,
  output logic [5:0]              pp_exp,
  output logic [5:0]              pp_shift,
  output logic [LANE_W-1:0]       pp_lane,
  output logic                    pp_last,
  output logic [5:0]              group_max_exp
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_e                 state_q, state_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [LANES*IMG_W-1:0] img_q, img_d;
  logic [LANES*WGT_W-1:0] wgt_q, wgt_d;
  logic [EXP_W-1:0]       max_q, max_d;

  logic [IMG_W-1:0]       sel_img;
  logic [WGT_W-1:0]       sel_wgt;
  logic [DPP_W-1:0]       lane_denorm;
  logic [EXP_W-1:0]       lane_exp;
  logic                   emit;
  logic                   at_last;

  always_comb begin
    sel_img = '0;
    sel_wgt = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (lane_q == LANE_W'(k)) begin
        sel_img = img_q[k*IMG_W +: IMG_W];
        sel_wgt = wgt_q[k*WGT_W +: WGT_W];
      end
    end
  end

  // One compute unit shared by both passes via the lane mux.
  pp_lane_compute u_compute (
    .img      (sel_img),
    .wgt      (sel_wgt),
    .denorm   (lane_denorm),
    .lane_exp (lane_exp)
  );

  assign emit    = (state_q == EMIT);
  assign at_last = (lane_q == LAST_LANE);

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    img_d   = img_q;
    wgt_d   = wgt_q;
    max_d   = max_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          img_d   = in_images;
          wgt_d   = in_weights;
          lane_d  = '0;
          max_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (lane_exp > max_q) max_d = lane_exp;
        if (at_last) begin
          lane_d  = '0;
          state_d = EMIT;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      EMIT: begin
        if (pp_ready) begin
          if (at_last) begin
            lane_d  = '0;
            state_d = IDLE;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      img_q   <= '0;
      wgt_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      img_q   <= img_d;
      wgt_q   <= wgt_d;
      max_q   <= max_d;
    end
  end

  // Beat fields are gated so they read zero whenever no beat is offered.
  always_comb begin
    in_ready      = (state_q == IDLE);
    pp_valid      = emit;
    pp_denorm     = emit ? lane_denorm : '0;
    pp_exp        = emit ? lane_exp : '0;
    pp_shift      = emit ? (max_q - lane_exp) : '0;
    pp_lane       = emit ? lane_q : '0;
    pp_last       = emit && at_last;
    group_max_exp = max_q;
  end

endmodule

// File: tb/tb_pp_lane_scheduler.sv
// Randomized and directed bench for pp_lane_scheduler against a timeline-based group model.
module tb_pp_lane_scheduler;

  localparam int LANES  = 9;
  localparam int LANE_W = $clog2(LANES);

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*8-1:0]   in_images;
  logic [LANES*4-1:0]   in_weights;
  logic                 pp_valid;
  logic                 pp_ready;
  logic [3:0]           pp_denorm;
  logic [5:0]           pp_exp;
  logic [5:0]           pp_shift;
  logic [LANE_W-1:0]    pp_lane;
  logic                 pp_last;
  logic [5:0]           group_max_exp;

  int n_checks = 0;
  int n_err    = 0;

  pp_lane_scheduler #(.LANES(LANES)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_images     (in_images),
    .in_weights    (in_weights),
    .pp_valid      (pp_valid),
    .pp_ready      (pp_ready),
    .pp_denorm     (pp_denorm),
    .pp_exp        (pp_exp),
    .pp_shift      (pp_shift),
    .pp_lane       (pp_lane),
    .pp_last       (pp_last),
    .group_max_exp (group_max_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Model: m_t = -1 idle, 0..LANES-1 scanning lane m_t, LANES..2*LANES-1 emitting beat m_t-LANES.
  int  m_t     = -1;
  int  m_hold  = 0;
  int  e_den[LANES];
  int  e_exp[LANES];
  int  e_max   = 0;
  bit  started = 0;

  task automatic model_capture();
    int ie, we, is, ws, im;
    logic [7:0] img;
    logic [3:0] wgt;
    e_max = 0;
    for (int k = 0; k < LANES; k++) begin
      img = in_images[k*8 +: 8];
      wgt = in_weights[k*4 +: 4];
      is = int'(img[7]);  ie = int'(img[6:2]); im = int'(img[1:0]);
      ws = int'(wgt[3]);  we = int'(wgt[2:0]);
      if ((img[6:0] == 7'd0) || (we == 7)) begin
        e_den[k] = 0;
        e_exp[k] = 0;
      end else begin
        e_den[k] = ((is ^ ws) * 8) + 4 + im;
        e_exp[k] = ie + we;
      end
      if (e_exp[k] > e_max) e_max = e_exp[k];
    end
  endtask

  initial begin
    int b, run_max;
    forever begin
      @(negedge clk);
      if (started) begin
        b = m_t - LANES;
        chk("in_ready", int'(in_ready), (m_t < 0) ? 1 : 0);
        chk("pp_valid", int'(pp_valid), (b >= 0) ? 1 : 0);
        if (b >= 0) begin
          chk("pp_denorm", int'(pp_denorm), e_den[b]);
          chk("pp_exp",    int'(pp_exp),    e_exp[b]);
          chk("pp_shift",  int'(pp_shift),  e_max - e_exp[b]);
          chk("pp_lane",   int'(pp_lane),   b);
          chk("pp_last",   int'(pp_last),   (b == LANES - 1) ? 1 : 0);
          chk("max_emit",  int'(group_max_exp), e_max);
        end else begin
          chk("pp_last_idle", int'(pp_last), 0);
          if (m_t < 0) chk("max_idle", int'(group_max_exp), m_hold);
          else begin
            run_max = 0;
            for (int k = 0; k < m_t; k++) if (e_exp[k] > run_max) run_max = e_exp[k];
            chk("max_scan", int'(group_max_exp), run_max);
          end
        end
      end
      if (!rst_n) begin
        started = 1;
        m_t     = -1;
        m_hold  = 0;
      end else if (started) begin
        if (m_t < 0) begin
          if (in_valid) begin
            model_capture();
            m_t = 0;
          end
        end else if (m_t < LANES) begin
          m_t++;
        end else if (pp_ready) begin
          if (m_t - LANES == LANES - 1) begin
            m_t    = -1;
            m_hold = e_max;
          end else begin
            m_t++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_group(input logic [LANES*8-1:0] imgs, input logic [LANES*4-1:0] wgts);
    logic acc;
    acc = 1'b0;
    in_images  = imgs;
    in_weights = wgts;
    in_valid   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      acc = in_ready;
      tick();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_beat(input int lane);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pp_valid && (int'(pp_lane) == lane)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("beat_timeout", 0, 1);
  endtask

  function automatic logic [7:0] rand_img();
    if ($urandom_range(0, 7) == 0) return 8'h80;
    return 8'($urandom);
  endfunction

  task automatic rand_vectors(output logic [LANES*8-1:0] imgs, output logic [LANES*4-1:0] wgts);
    for (int k = 0; k < LANES; k++) begin
      imgs[k*8 +: 8] = rand_img();
      wgts[k*4 +: 4] = 4'($urandom);
    end
  endtask

  initial begin
    logic [LANES*8-1:0] imgs;
    logic [LANES*4-1:0] wgts;
    rst_n = 1'b0; in_valid = 1'b0; pp_ready = 1'b1;
    in_images = '0; in_weights = '0;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_pp_valid", int'(pp_valid), 0);
    chk("rst_max",      int'(group_max_exp), 0);
    chk("rst_pp_lane",  int'(pp_lane), 0);
    tick();

    // Known group: two live lanes, weight-zero lane, negative-zero image, zero image lanes.
    imgs = '0; wgts = '0;
    imgs[0*8 +: 8] = 8'h3E; wgts[0*4 +: 4] = 4'b0010;
    imgs[1*8 +: 8] = 8'h8D; wgts[1*4 +: 4] = 4'b1000;
    imgs[2*8 +: 8] = 8'h7C; wgts[2*4 +: 4] = 4'b0111;
    imgs[3*8 +: 8] = 8'h80; wgts[3*4 +: 4] = 4'b0010;
    send_group(imgs, wgts);
    wait_beat(0);
    chk("a_b0_denorm", int'(pp_denorm), 6);
    chk("a_b0_exp",    int'(pp_exp), 17);
    chk("a_b0_shift",  int'(pp_shift), 0);
    chk("a_max",       int'(group_max_exp), 17);
    wait_beat(1);
    chk("a_b1_denorm", int'(pp_denorm), 5);
    chk("a_b1_exp",    int'(pp_exp), 3);
    chk("a_b1_shift",  int'(pp_shift), 14);
    wait_beat(2);
    chk("a_wzero_den",   int'(pp_denorm), 0);
    chk("a_wzero_shift", int'(pp_shift), 17);
    wait_beat(3);
    chk("a_negz_exp",   int'(pp_exp), 0);
    chk("a_negz_shift", int'(pp_shift), 17);
    wait_beat(8);
    chk("a_last", int'(pp_last), 1);
    @(negedge clk);
    chk("a_ready_back", int'(in_ready), 1);
    tick();

    // Maximum exponent in the final lane.
    rand_vectors(imgs, wgts);
    imgs[8*8 +: 8] = 8'h7C; wgts[8*4 +: 4] = 4'b0110;
    send_group(imgs, wgts);
    wait_beat(8);
    chk("max37_max",   int'(group_max_exp), 37);
    chk("max37_shift", int'(pp_shift), 0);
    chk("max37_den",   int'(pp_denorm), 4);
    tick();

    // All-zero group.
    for (int k = 0; k < LANES; k++) begin
      imgs[k*8 +: 8] = (k % 2 == 0) ? 8'h80 : 8'($urandom);
      wgts[k*4 +: 4] = (k % 2 == 0) ? 4'($urandom) : 4'b1111;
    end
    send_group(imgs, wgts);
    wait_beat(4);
    chk("zero_max",   int'(group_max_exp), 0);
    chk("zero_shift", int'(pp_shift), 0);
    tick();

    // Backpressure on beat 1.
    rand_vectors(imgs, wgts);
    send_group(imgs, wgts);
    wait_beat(0);
    tick();
    pp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_lane_hold", int'(pp_lane), 1);
    end
    tick();
    pp_ready = 1'b1;
    wait_beat(2);
    tick();

    // Reset while beat 3 is presented.
    rand_vectors(imgs, wgts);
    send_group(imgs, wgts);
    wait_beat(2);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_pp_valid", int'(pp_valid), 0);
    chk("mrst_pp_lane",  int'(pp_lane), 0);
    chk("mrst_max",      int'(group_max_exp), 0);
    chk("mrst_in_ready", int'(in_ready), 1);
    tick();
    rand_vectors(imgs, wgts);
    send_group(imgs, wgts);
    wait_beat(8);
    tick();

    // in_valid held high with inputs churning every cycle and random backpressure.
    in_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      rand_vectors(imgs, wgts);
      in_images  = imgs;
      in_weights = wgts;
      pp_ready   = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    pp_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pp_lane_scheduler.md
Name: pp_lane_scheduler

Overview:
Time-multiplexes one partial-product unit across the LANES image/weight pairs of a kernel window. Two passes per group:
- SCAN computes every lane's product exponent and the group maximum.
- EMIT streams each lane's denormalized PP, exponent and alignment shift (max − exp) to the downstream adder tree over a valid/ready handshake.

It sits between the window buffer and the MAC accumulator.

Parameters:
LANES, 9, lanes per group (3x3 kernel); legal range 2..16
LANE_W, $clog2(LANES), lane index width (derived, not overridable)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  group offered by upstream
in_ready  out  1  scheduler accepts a group (high only in IDLE)
in_images  in  LANES*8  lane k at [8k+7:8k]; format S|E[4:0]|M[1:0]
in_weights  in  LANES*4  lane k at [4k+3:4k]; format S|E[2:0], E=3'b111 means zero
pp_valid  out  1  PP beat valid
pp_ready  in  1  downstream accepts beat
pp_denorm  out  4  {sign, leading 1, mant[1:0]}, or 0 when lane is zero
pp_exp  out  6  image_exp + weight_exp, or 0 when lane is zero
pp_shift  out  6  group_max_exp − pp_exp
pp_lane  out  LANE_W  lane index of the beat
pp_last  out  1  final lane of the group
group_max_exp  out  6  maximum non-zero lane exponent; stable during EMIT

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Per-lane PP function (combinational):
  - zero = (image[6:0]==0) OR (weight[2:0]==3'b111).
  - Non-zero: denorm = {img_s^wgt_s, 1'b1, img_m}; exp = {1'b0,img_e} + {3'b0,wgt_e}; max is 31+6=37, no overflow.
  - Zero: denorm = 4'b0000, exp = 6'd0.
- FSM states: IDLE, SCAN, EMIT. Registers: state, lane counter, captured images/weights, max register.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, lane=0, group_max_exp=0, captured data cleared.
  - pp_valid=0, pp_last=0; pp_denorm/pp_exp/pp_shift/pp_lane read 0.
  - in_valid is ignored while rst_n=0.
- Reset mid-operation (SCAN or EMIT): the group is discarded with no further beats. in_ready=1 in the first cycle after rst_n returns high.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture both vectors, lane←0, max←0, go to SCAN.
- SCAN, one lane per cycle:
  - max←max(max, exp[lane]); zero lanes contribute 0.
  - After lane LANES−1: lane←0, go to EMIT.
  - in_ready=0 and pp_valid=0 throughout.
- EMIT:
  - pp_valid=1. Outputs are driven from registers plus the lane mux.
  - pp_shift = group_max_exp − pp_exp: never negative; zero lanes report shift = group_max_exp.
  - Lane advances only on pp_valid&&pp_ready.
  - pp_last=1 when lane==LANES−1. The handshake on that beat goes to IDLE.
  - While pp_ready=0, all pp_* outputs hold stable.
- No overlap between groups. Minimum period is 1 + LANES + LANES cycles: accept, scan, emit.
- All-zero group: group_max_exp=0, every beat has denorm=0, exp=0, shift=0.
- Input pins change during SCAN/EMIT: no effect, because data is captured at accept.

Decomposition:
- Package pp_pkg:
  - widths IMG_W=8, WGT_W=4, EXP_W=6, DPP_W=4;
  - WGT_ZERO_EXP=3'b111;
  - state enum {IDLE, SCAN, EMIT}.
- Sub-module pp_lane_compute: the combinational per-lane PP function. Instantiated once, fed through a lane-indexed mux from the captured vectors, and shared by SCAN and EMIT.

Test Plan:
- Two-lane group (LANES=2, pp_ready=1):
  - Inputs: lane0 img=0x3E, wgt=4'b0010; lane1 img=0x8D, wgt=4'b1000.
  - Beat0: denorm=4'b0110, exp=17, shift=0.
  - Beat1: denorm=4'b0101, exp=3, shift=14, pp_last=1.
  - group_max_exp=17; in_ready returns 1 exactly 2 cycles after the last beat's SCAN start + 2 handshakes.
- Zero detection:
  - Lane with wgt=4'b0111 or img=0x80 (negative zero): denorm=0, exp=0, shift=max.
  - All-zero group: max=0, all shifts 0.
- Backpressure: pp_ready held 0 for 5 cycles on beat 1 → pp_* outputs stable, lane does not advance, no duplicated or dropped beat.
- Max exponent (LANES=9): img=0x7C (e=31), wgt=4'b0110 (e=6) in lane 8 → group_max_exp=37, lane 8 shift=0.
- Reset mid-EMIT: rst_n=0 at beat 3 → next cycle pp_valid=0, lane=0, group_max_exp=0. After release, in_ready=1 and a new group is accepted and processed cleanly.
- Held input: in_valid held high with in_ready=0 during SCAN/EMIT → exactly one group accepted per IDLE visit.
